parking_spot_manager: RTL and testbench

//  Writer side of the parking occupancy vector: owns the per-spot occupied bits that the capacity counter reads.

---
 rtl/parking_spot_manager.sv | 179 +++++++++++++++++
 tb/tb_parking_spot_manager.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_spot_manager.sv
// Parking occupancy writer: allocates the lowest free spot on entry, releases spots on exit, times the barriers.
// Optional PARKING_STATS_EN adds saturating total_entries / total_rejects counters.
module parking_spot_manager #(
  parameter int unsigned NUM_SPOTS   = 8,
  parameter int unsigned ID_W        = 3,
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [ID_W-1:0]      exit_spot,
  output logic                 entry_ack,
  output logic [ID_W-1:0]      entry_spot,
  output logic                 entry_full,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic                 gate_in_open,
  output logic                 gate_out_open,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [ID_W:0]        parked_cnt
`ifdef PARKING_STATS_EN
  ,
  output logic [15:0]          total_entries,
  output logic [15:0]          total_rejects
`endif
);

  localparam int unsigned CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ENTRY_CHK = 3'd1,
    EXIT_CHK  = 3'd2,
    GATE_IN   = 3'd3,
    GATE_OUT  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     gate_cnt, gate_cnt_d;
  logic [NUM_SPOTS-1:0] occ_d;
  logic [ID_W-1:0]      entry_spot_d, free_idx;
  logic [ID_W:0]        parked_cnt_d;
  logic                 entry_ack_d, entry_full_d, exit_ack_d, exit_err_d;
  logic                 gate_in_d, gate_out_d;
  logic                 lot_full, exit_valid;

  // Lowest-index free spot: scanning downward lets the lowest index win
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) free_idx = ID_W'(i);
    end
  end

  assign lot_full   = &occupancy;
  assign exit_valid = ({1'b0, exit_spot} < (ID_W+1)'(NUM_SPOTS)) && occupancy[exit_spot];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; exit wins over a simultaneous entry
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (exit_req)       state_nxt = EXIT_CHK;
        else if (entry_req) state_nxt = ENTRY_CHK;
      end
      ENTRY_CHK: state_nxt = lot_full ? IDLE : GATE_IN;
      EXIT_CHK:  state_nxt = exit_valid ? GATE_OUT : IDLE;
      GATE_IN:   if (gate_cnt == '0) state_nxt = IDLE;
      GATE_OUT:  if (gate_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    occ_d        = occupancy;
    entry_spot_d = entry_spot;
    gate_cnt_d   = gate_cnt;
    entry_ack_d  = 1'b0;
    entry_full_d = 1'b0;
    exit_ack_d   = 1'b0;
    exit_err_d   = 1'b0;
    gate_in_d    = 1'b0;
    gate_out_d   = 1'b0;
    case (state)
      ENTRY_CHK: begin
        if (!lot_full) begin
          occ_d[free_idx] = 1'b1;
          entry_spot_d    = free_idx;
          entry_ack_d     = 1'b1;
          gate_in_d       = 1'b1;
          gate_cnt_d      = CNT_W'(GATE_CYCLES - 1);
        end else begin
          entry_full_d = 1'b1;
        end
      end
      EXIT_CHK: begin
        if (exit_valid) begin
          occ_d[exit_spot] = 1'b0;
          exit_ack_d       = 1'b1;
          gate_out_d       = 1'b1;
          gate_cnt_d       = CNT_W'(GATE_CYCLES - 1);
        end else begin
          exit_err_d = 1'b1;
        end
      end
      GATE_IN: begin
        if (gate_cnt != '0) begin
          gate_cnt_d = gate_cnt - 1'b1;
          gate_in_d  = 1'b1;
        end
      end
      GATE_OUT: begin
        if (gate_cnt != '0) begin
          gate_cnt_d = gate_cnt - 1'b1;
          gate_out_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Parked count follows the next occupancy so both update on the same edge
  always_comb begin
    parked_cnt_d = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      parked_cnt_d = parked_cnt_d + (ID_W+1)'(occ_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy     <= '0;
      parked_cnt    <= '0;
      entry_spot    <= '0;
      gate_cnt      <= '0;
      entry_ack     <= 1'b0;
      entry_full    <= 1'b0;
      exit_ack      <= 1'b0;
      exit_err      <= 1'b0;
      gate_in_open  <= 1'b0;
      gate_out_open <= 1'b0;
    end else begin
      occupancy     <= occ_d;
      parked_cnt    <= parked_cnt_d;
      entry_spot    <= entry_spot_d;
      gate_cnt      <= gate_cnt_d;
      entry_ack     <= entry_ack_d;
      entry_full    <= entry_full_d;
      exit_ack      <= exit_ack_d;
      exit_err      <= exit_err_d;
      gate_in_open  <= gate_in_d;
      gate_out_open <= gate_out_d;
    end
  end

`ifdef PARKING_STATS_EN
  // Saturating usage statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_entries <= '0;
      total_rejects <= '0;
    end else begin
      if (entry_ack_d && (total_entries != 16'hFFFF))
        total_entries <= total_entries + 16'd1;
      if ((entry_full_d || exit_err_d) && (total_rejects != 16'hFFFF))
        total_rejects <= total_rejects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parking_spot_manager.sv
// Scoreboard bench for parking_spot_manager: a reference occupancy model pushes the expected
// response for each request; a negedge monitor pops and compares whenever a response pulse appears.
module tb_parking_spot_manager;

  localparam int unsigned NUM_SPOTS   = 8;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned GATE_CYCLES = 4;

  localparam logic [3:0] K_ACK  = 4'b1000;
  localparam logic [3:0] K_FULL = 4'b0100;
  localparam logic [3:0] K_XACK = 4'b0010;
  localparam logic [3:0] K_XERR = 4'b0001;

  logic                 clk, rst_n;
  logic                 entry_req, exit_req;
  logic [ID_W-1:0]      exit_spot;
  logic                 entry_ack, entry_full, exit_ack, exit_err;
  logic [ID_W-1:0]      entry_spot;
  logic                 gate_in_open, gate_out_open;
  logic [NUM_SPOTS-1:0] occupancy;
  logic [ID_W:0]        parked_cnt;
`ifdef PARKING_STATS_EN
  logic [15:0]          total_entries, total_rejects;
`endif

  parking_spot_manager #(
    .NUM_SPOTS  (NUM_SPOTS),
    .ID_W       (ID_W),
    .GATE_CYCLES(GATE_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .exit_spot    (exit_spot),
    .entry_ack    (entry_ack),
    .entry_spot   (entry_spot),
    .entry_full   (entry_full),
    .exit_ack     (exit_ack),
    .exit_err     (exit_err),
    .gate_in_open (gate_in_open),
    .gate_out_open(gate_out_open),
    .occupancy    (occupancy),
    .parked_cnt   (parked_cnt)
`ifdef PARKING_STATS_EN
    ,
    .total_entries(total_entries),
    .total_rejects(total_rejects)
`endif
  );

  typedef struct {
    logic [3:0]           kind;
    logic [ID_W-1:0]      spot;
    logic [NUM_SPOTS-1:0] occ;
    logic [ID_W:0]        cnt;
  } exp_t;

  exp_t                 sb[$];
  logic [NUM_SPOTS-1:0] m_occ;
  int                   checks = 0;
  int                   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lowest free spot found by an ascending scan
  function automatic void push_entry();
    exp_t e;
    bit   found;
    e = '{kind: K_FULL, spot: '0, occ: '0, cnt: '0};
    found = 1'b0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      if (!found && !m_occ[i]) begin
        found    = 1'b1;
        e.spot   = ID_W'(i);
        e.kind   = K_ACK;
        m_occ[i] = 1'b1;
      end
    end
    e.occ = m_occ;
    e.cnt = (ID_W+1)'($countones(m_occ));
    sb.push_back(e);
  endfunction

  function automatic void push_exit(input logic [ID_W-1:0] s);
    exp_t e;
    e = '{kind: K_XERR, spot: '0, occ: '0, cnt: '0};
    if (m_occ[s]) begin
      m_occ[s] = 1'b0;
      e.kind   = K_XACK;
    end
    e.occ = m_occ;
    e.cnt = (ID_W+1)'($countones(m_occ));
    sb.push_back(e);
  endfunction

  // Monitor: every response pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (entry_ack || entry_full || exit_ack || exit_err)) begin
      exp_t e;
      check("pulse_onehot", 32'($countones({entry_ack, entry_full, exit_ack, exit_err})), 32'd1);
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_kind", 32'({entry_ack, entry_full, exit_ack, exit_err}), 32'(e.kind));
        if (e.kind == K_ACK) check("entry_spot", 32'(entry_spot), 32'(e.spot));
        check("occupancy", 32'(occupancy), 32'(e.occ));
        check("parked_cnt", 32'(parked_cnt), 32'(e.cnt));
      end
    end
  end

  // Wait (bounded) for the response, drop the request, then measure the barrier open time
  task automatic wait_done(input bit is_entry);
    bit seen, grant;
    int n;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (is_entry ? (entry_ack || entry_full) : (exit_ack || exit_err)) seen = 1'b1;
    end
    check(is_entry ? "entry_resp_seen" : "exit_resp_seen", 32'(seen), 32'd1);
    grant = is_entry ? entry_ack : exit_ack;
    if (is_entry) entry_req = 1'b0;
    else          exit_req  = 1'b0;
    if (seen) begin
      n = 0;
      while ((is_entry ? gate_in_open : gate_out_open) && n < 20) begin
        n++;
        @(negedge clk);
      end
      check(is_entry ? "gate_in_len" : "gate_out_len", 32'(n), grant ? 32'(GATE_CYCLES) : 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic do_entry();
    push_entry();
    entry_req = 1'b1;
    wait_done(1'b1);
  endtask

  task automatic do_exit(input logic [ID_W-1:0] s);
    push_exit(s);
    exit_spot = s;
    exit_req  = 1'b1;
    wait_done(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst_n     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_spot = '0;
    m_occ     = '0;
    repeat (3) @(negedge clk);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_parked", 32'(parked_cnt), 32'd0);
    check("rst_spot", 32'(entry_spot), 32'd0);
    check("rst_gates", 32'({gate_in_open, gate_out_open}), 32'd0);
    check("rst_pulses", 32'({entry_ack, entry_full, exit_ack, exit_err}), 32'd0);
`ifdef PARKING_STATS_EN
    check("rst_stats", 32'({total_entries, total_rejects}), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Three entries take spots 0,1,2
    repeat (3) do_entry();
    check("occ_after3", 32'(occupancy), 32'h07);
    check("cnt_after3", 32'(parked_cnt), 32'd3);

    // Occupancy 0x0F, release spot 1, next entry reuses it
    do_entry();
    check("occ_0f", 32'(occupancy), 32'h0F);
    do_exit(3'd1);
    check("occ_0d", 32'(occupancy), 32'h0D);
    do_entry();
    check("spot_reuse_hold", 32'(entry_spot), 32'd1);

    // Exit of an empty spot is rejected without side effects
    do_exit(3'd5);
    check("occ_after_err", 32'(occupancy), 32'h0F);
    check("cnt_after_err", 32'(parked_cnt), 32'd4);

    // Fill the lot, then one more entry is refused
    repeat (4) do_entry();
    check("occ_full", 32'(occupancy), 32'hFF);
    do_entry();
    check("cnt_full", 32'(parked_cnt), 32'd8);

    // Simultaneous requests: exit first, then the still-pending entry gets spot 0
    push_exit(3'd0);
    push_entry();
    exit_spot = 3'd0;
    exit_req  = 1'b1;
    entry_req = 1'b1;
    wait_done(1'b0);
    wait_done(1'b1);
    check("occ_after_simul", 32'(occupancy), 32'hFF);

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) do_entry();
      else do_exit(ID_W'($urandom_range(0, NUM_SPOTS - 1)));
    end
    check("occ_random", 32'(occupancy), 32'(m_occ));
    check("cnt_random", 32'(parked_cnt), 32'($countones(m_occ)));

    // Reset in the middle of GATE_IN
    if (m_occ == '1) do_exit(3'd4);
    push_entry();
    entry_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (entry_ack) got = 1'b1;
    end
    check("rst_test_ack", 32'(got), 32'd1);
    entry_req = 1'b0;
    @(negedge clk);
    check("gate_open_before_rst", 32'(gate_in_open), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_gate_in", 32'(gate_in_open), 32'd0);
    check("rst_occ_mid", 32'(occupancy), 32'd0);
    check("rst_cnt_mid", 32'(parked_cnt), 32'd0);
`ifdef PARKING_STATS_EN
    check("rst_stats_mid", 32'({total_entries, total_rejects}), 32'd0);
`endif
    m_occ = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_entry();
    check("post_rst_spot", 32'(entry_spot), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
